pixel_dispatch_scheduler: RTL and testbench
===========================================

Name: pixel_dispatch_scheduler

Overview:
- Shares one frame-scan pixel coordinate generator among NUM_REQ pixel compute engines (e.g. Mandelbrot/rainbow cores).
- Hands out each (X,Y) of a frame exactly once, in raster order, to requesting idle engines using round-robin arbitration.
- Tracks outstanding pixels, then signals frame completion once every engine has returned.

Parameters:
NUM_REQ, 4, number of compute engines (2..8)
X_W, 10, X coordinate width
Y_W, 10, Y coordinate width
H_PIXELS, 1024, pixels per line (<= 2**X_W)
V_LINES, 768, lines per frame (<= 2**Y_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a frame when IDLE
req  in  NUM_REQ  per-engine request for a pixel
done_in  in  NUM_REQ  per-engine pulse; granted pixel finished
gnt  out  NUM_REQ  one-hot grant, combinational, valid same cycle
gnt_x  out  X_W  X of granted pixel (valid when |gnt)
gnt_y  out  Y_W  Y of granted pixel (valid when |gnt)
gnt_last  out  1  granted pixel is (H_PIXELS-1, V_LINES-1)
busy  out  1  state != IDLE
frame_done  out  1  registered one-cycle pulse at frame completion
err  out  1  sticky; done_in seen for an engine with no outstanding pixel

Behaviour:
- Reset values: state IDLE; X, Y counters 0; rr pointer 0; eng_busy all 0; frame_done 0; err 0. gnt is 0 in IDLE.
- States:
  - IDLE: start=1 -> RUN next cycle. Counters are already 0.
  - RUN: grants are issued.
  - DRAIN: no grants; waits for eng_busy == 0.
- RUN/DRAIN: start is ignored.
- Eligibility: elig[i] = req[i] & ~eng_busy[i]. eng_busy is the registered per-engine outstanding flag.
- Arbitration (RUN only):
  - Search starts at index rr and wraps modulo NUM_REQ; the first eligible engine wins.
  - At most one grant per cycle.
  - On a grant to engine k: rr <= (k+1) mod NUM_REQ next cycle. rr is unchanged with no grant.
- Grant effects, next cycle:
  - eng_busy[k] <= 1.
  - X <= X+1. If X == H_PIXELS-1: X <= 0 and Y <= Y+1.
  - gnt_x/gnt_y show the pre-increment counter values.
- Last pixel: a grant with X == H_PIXELS-1 and Y == V_LINES-1 asserts gnt_last. Next cycle: X, Y <= 0 and state -> DRAIN.
- done_in[i]:
  - If eng_busy[i]=1: eng_busy[i] <= 0 next cycle.
  - If eng_busy[i]=0: ignored, err <= 1 (sticky until rst).
  - done_in and req from the same engine in one cycle: the engine is not eligible that cycle. Earliest regrant is the following cycle.
  - Multiple done_in bits in one cycle are all honoured.
- DRAIN:
  - Exits when eng_busy == 0 and no done_in is pending, evaluated on the registered value.
  - On exit: frame_done=1 for exactly one cycle, state -> IDLE.
  - A start in the same cycle as frame_done is ignored. A new frame needs start while IDLE with frame_done low.
- Frame latency: the first grant is possible in the cycle after start. Minimum frame length is H_PIXELS*V_LINES grant cycles plus drain.
- rst mid-frame: all state returns to reset values in the next cycle. No frame_done pulse. Outstanding engine results are discarded by the system.

Optional Feature:
- Macro: PIXEL_SCHED_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in RUN: no grant that cycle, state -> DRAIN, X/Y <= 0.
  - Drain then completes normally. frame_done pulses with aborted=1 in the same cycle (aborted=0 otherwise, reset 0).
  - abort in IDLE or DRAIN: no effect.
- When not defined: neither port exists and behaviour is as above.

Test Plan:
1. NUM_REQ=2, H=4, V=2. start; req=2'b11; each engine returns done_in 1 cycle after its grant.
   -> Grants alternate 01,10,01,...; coordinates (0,0),(1,0),(2,0),(3,0),(0,1)...(3,1); gnt_last on the 8th grant; frame_done 1 cycle after drain; busy falls together with frame_done.
2. Single requester req=2'b01, done_in held off 3 cycles.
   -> No regrant while eng_busy[0]=1; next grant is the cycle after done_in is registered; coordinates contiguous with no skipped pixel.
3. done_in[1] pulsed with no outstanding pixel.
   -> err=1 and stays 1; X/Y and grants unaffected.
4. Last pixel granted while both engines are busy; engine 1 finishes 5 cycles later than engine 0.
   -> State DRAIN; frame_done only after the later done_in; start during DRAIN ignored (busy stays 1).
5. rst asserted after 3 grants.
   -> Next cycle: gnt=0, busy=0, X=Y=0, eng_busy=0, no frame_done. A new start restarts at (0,0).
6. (PIXEL_SCHED_ABORT_EN) abort after 2 grants, one engine outstanding.
   -> No further grants; frame_done and aborted pulse together after that done_in; the next frame begins at (0,0).

Source files
------------

// File: rtl/pixel_dispatch_scheduler.sv
// Pixel dispatch scheduler: hands out every (X,Y) of a frame once, in raster order, to NUM_REQ engines by round-robin.
// Optional abort/aborted port pair is enabled by defining PIXEL_SCHED_ABORT_EN.
module pixel_dispatch_scheduler #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned H_PIXELS = 1024,
    parameter int unsigned V_LINES  = 768
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done_in,
`ifdef PIXEL_SCHED_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [X_W-1:0]     gnt_x,
    output logic [Y_W-1:0]     gnt_y,
    output logic               gnt_last,
    output logic               busy,
    output logic               frame_done,
    output logic               err
);
    localparam int unsigned     RR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [X_W-1:0]  X_LAST  = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(V_LINES - 1);
    localparam logic [RR_W-1:0] RR_LAST = RR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [NUM_REQ-1:0] eng_busy_q, eng_busy_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] elig;
    logic               win_valid;
    logic [RR_W-1:0]    win_idx;
    logic [RR_W-1:0]    cand;
    logic               run_grant;
    logic               abort_c;

    assign elig = req & ~eng_busy_q;

    // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = RR_W'((32'(rr_q) + off) % NUM_REQ);
            if (!win_valid && elig[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign run_grant = (state_q == RUN) && !abort_c && win_valid;
    assign gnt       = run_grant ? (NUM_REQ'(1) << win_idx) : '0;
    assign gnt_x     = x_q;
    assign gnt_y     = y_q;
    assign gnt_last  = run_grant && (x_q == X_LAST) && (y_q == Y_LAST);
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            rr_q         <= '0;
            eng_busy_q   <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rr_q         <= rr_d;
            eng_busy_q   <= eng_busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Next-state: raster counters, round-robin pointer and per-engine outstanding flags.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        rr_d         = rr_q;
        eng_busy_d   = (eng_busy_q & ~done_in) | gnt;
        frame_done_d = 1'b0;
        err_d        = err_q | (|(done_in & ~eng_busy_q));
        unique case (state_q)
            IDLE: begin
                // a start coinciding with the completion pulse is dropped
                if (start && !frame_done_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_c) begin
                    state_d = DRAIN;
                    x_d     = '0;
                    y_d     = '0;
                end else if (run_grant) begin
                    rr_d = (win_idx == RR_LAST) ? '0 : win_idx + RR_W'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + Y_W'(1);
                        end
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end
            DRAIN: begin
                if ((eng_busy_q == '0) && (done_in == '0)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PIXEL_SCHED_ABORT_EN
    logic abort_flag_q;
    logic aborted_q;

    assign abort_c = abort;
    assign aborted = aborted_q;

    // Remembers that the frame was cut short so the completion pulse can report it.
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_flag_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            aborted_q <= frame_done_d & abort_flag_q;
            if (frame_done_d) begin
                abort_flag_q <= 1'b0;
            end else if ((state_q == RUN) && abort) begin
                abort_flag_q <= 1'b1;
            end
        end
    end
`else
    assign abort_c = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_dispatch_scheduler.sv
// Self-checking bench for pixel_dispatch_scheduler: 2 engines, 4x2 frame, pixel-index reference model.
module tb_pixel_dispatch_scheduler;
    localparam int NR   = 2;
    localparam int XW   = 3;
    localparam int YW   = 2;
    localparam int HP   = 4;
    localparam int VL   = 2;
    localparam int NPIX = HP * VL;
`ifdef PIXEL_SCHED_ABORT_EN
    localparam int OW = NR + XW + YW + 5;
`else
    localparam int OW = NR + XW + YW + 4;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [NR-1:0] req;
    logic [NR-1:0] done_in;
    logic          ab_in;
    logic [NR-1:0] gnt;
    logic [XW-1:0] gnt_x;
    logic [YW-1:0] gnt_y;
    logic          gnt_last;
    logic          busy;
    logic          frame_done;
    logic          err;
`ifdef PIXEL_SCHED_ABORT_EN
    logic          aborted;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state: pixel index instead of X/Y counters
    int            m_phase;
    int            m_pix;
    int            m_rr;
    logic [NR-1:0] m_busy;
    bit            m_err, m_fd, m_ab, m_abflag;
    logic [NR-1:0] e_gnt;
    logic [OW-1:0] exp_vec;

    int cnt[NR];
    int lat[NR];

    pixel_dispatch_scheduler #(
        .NUM_REQ (NR),
        .X_W     (XW),
        .Y_W     (YW),
        .H_PIXELS(HP),
        .V_LINES (VL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .req       (req),
        .done_in   (done_in),
`ifdef PIXEL_SCHED_ABORT_EN
        .abort     (ab_in),
        .aborted   (aborted),
`endif
        .gnt       (gnt),
        .gnt_x     (gnt_x),
        .gnt_y     (gnt_y),
        .gnt_last  (gnt_last),
        .busy      (busy),
        .frame_done(frame_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic model_reset();
        m_phase = 0; m_pix = 0; m_rr = 0; m_busy = '0;
        m_err = 0; m_fd = 0; m_ab = 0; m_abflag = 0;
    endtask

    // Predicts this cycle's outputs from the current inputs, then advances one clock.
    task automatic model_step();
        int k, ph, idx;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        bit elast, old_any, nfd, nab;
        ph = m_phase;
        k  = -1;
        if (ph == 1 && !ab_in) begin
            for (int j = 0; j < NR; j++) begin
                idx = (m_rr + j) % NR;
                if (k < 0 && req[idx] && !m_busy[idx]) k = idx;
            end
        end
        e_gnt = '0;
        if (k >= 0) e_gnt[k] = 1'b1;
        ex    = (k >= 0) ? XW'(m_pix % HP) : '0;
        ey    = (k >= 0) ? YW'(m_pix / HP) : '0;
        elast = (k >= 0) && (m_pix == NPIX - 1);
`ifdef PIXEL_SCHED_ABORT_EN
        exp_vec = {e_gnt, ex, ey, elast, ph != 0, m_fd, m_err, m_ab};
`else
        exp_vec = {e_gnt, ex, ey, elast, ph != 0, m_fd, m_err};
`endif
        if (rst) begin
            model_reset();
        end else begin
            old_any = |m_busy;
            nfd = 0;
            nab = 0;
            for (int i = 0; i < NR; i++) begin
                if (done_in[i]) begin
                    if (m_busy[i]) m_busy[i] = 1'b0;
                    else m_err = 1;
                end
            end
            if (k >= 0) begin
                m_busy[k] = 1'b1;
                m_rr = (k + 1) % NR;
                m_pix++;
                if (m_pix == NPIX) begin
                    m_pix = 0;
                    m_phase = 2;
                end
            end
            if (ph == 0 && start && !m_fd) m_phase = 1;
            if (ph == 1 && ab_in) begin
                m_phase = 2; m_pix = 0; m_abflag = 1;
            end
            if (ph == 2 && !old_any && done_in == '0) begin
                m_phase = 0; nfd = 1; nab = m_abflag; m_abflag = 0;
            end
            m_fd = nfd;
            m_ab = nab;
        end
    endtask

    function automatic logic [OW-1:0] obs();
        logic [XW-1:0] ox;
        logic [YW-1:0] oy;
        ox = (|e_gnt) ? gnt_x : '0;
        oy = (|e_gnt) ? gnt_y : '0;
`ifdef PIXEL_SCHED_ABORT_EN
        return {gnt, ox, oy, gnt_last, busy, frame_done, err, aborted};
`else
        return {gnt, ox, oy, gnt_last, busy, frame_done, err};
`endif
    endfunction

    // Engine stand-ins: each returns done_in lat[i] cycles after its grant.
    task automatic drive(input bit st, input logic [NR-1:0] rq, input logic [NR-1:0] sp, input bit ab);
        done_in = sp;
        for (int i = 0; i < NR; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) done_in[i] = 1'b1;
            end
        end
        start = st;
        req   = rq;
        ab_in = ab;
        model_step();
        for (int i = 0; i < NR; i++) begin
            if (rst) cnt[i] = 0;
            else if (e_gnt[i]) cnt[i] = lat[i];
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            rst = (c < 2);
            drive(1'b1 && (c < 2), 2'b11, '0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", c, obs(), exp_vec);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alternate();
        int ngr = 0, nfd = 0, tail = 0;
        lat[0] = 1; lat[1] = 1;
        for (int c = 0; c < 60 && tail < 3; c++) begin
            drive(c == 0, 2'b11, '0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL alternate cyc=%0d got=%b exp=%b", c, obs(), exp_vec);
            end
            if (|gnt) ngr++;
            if (frame_done) nfd++;
            if (nfd > 0) tail++;
            @(posedge clk); #1;
        end
        checks++;
        if (ngr != NPIX) begin errors++; $display("FAIL alternate_grants got=%0d exp=%0d", ngr, NPIX); end
        checks++;
        if (nfd != 1) begin errors++; $display("FAIL alternate_frame_done got=%0d exp=1", nfd); end
    endtask

    task automatic test_single();
        int ngr = 0, nfd = 0, tail = 0, last_c = -1;
        lat[0] = 3; lat[1] = 3;
        for (int c = 0; c < 80 && tail < 3; c++) begin
            drive(c == 0, 2'b01, '0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL single cyc=%0d got=%b exp=%b", c, obs(), exp_vec);
            end
            if (|gnt) begin
                if (last_c >= 0) begin
                    checks++;
                    if (c - last_c != 4) begin
                        errors++;
                        $display("FAIL single_gap cyc=%0d got=%0d exp=4", c, c - last_c);
                    end
                end
                last_c = c;
                ngr++;
            end
            if (frame_done) nfd++;
            if (nfd > 0) tail++;
            @(posedge clk); #1;
        end
        checks++;
        if (ngr != NPIX) begin errors++; $display("FAIL single_grants got=%0d exp=%0d", ngr, NPIX); end
    endtask

    task automatic test_spurious_done();
        int nfd = 0, tail = 0;
        lat[0] = 1; lat[1] = 1;
        for (int c = 0; c < 60 && tail < 2; c++) begin
            drive(c == 0, 2'b01, (c == 3) ? 2'b10 : 2'b00, 1'b0);
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL spurious cyc=%0d got=%b exp=%b", c, obs(), exp_vec);
            end
            if (frame_done) nfd++;
            if (nfd > 0) tail++;
            @(posedge clk); #1;
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL spurious_err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_drain();
        int nfd = 0, tail = 0;
        lat[0] = 2; lat[1] = 7;
        for (int c = 0; c < 120 && tail < 4; c++) begin
            drive(c == 0 || m_phase == 2 || m_fd, 2'b11, '0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL drain cyc=%0d got=%b exp=%b", c, obs(), exp_vec);
            end
            if (frame_done) nfd++;
            if (nfd > 0) tail++;
            @(posedge clk); #1;
        end
        checks++;
        if (nfd != 1) begin errors++; $display("FAIL drain_frame_done got=%0d exp=1", nfd); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drain_restart got busy=%b exp=0", busy); end
    endtask

    task automatic test_rst_mid();
        int mg = 0, nfd = 0, tail = 0;
        bit first = 1;
        lat[0] = 2; lat[1] = 2;
        for (int c = 0; c < 30 && mg < 3; c++) begin
            drive(c == 0, 2'b11, '0, 1'b0);
            if (|e_gnt) mg++;
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", c, obs(), exp_vec);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(1'b0, 2'b11, '0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 60 && tail < 3; c++) begin
            drive(c == 0, 2'b11, '0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL rst_mid cyc=%0d got=%b exp=%b", c, obs(), exp_vec);
            end
            if (|gnt && first) begin
                first = 0;
                checks++;
                if (gnt_x !== '0 || gnt_y !== '0) begin
                    errors++;
                    $display("FAIL rst_mid_restart got=(%0d,%0d) exp=(0,0)", gnt_x, gnt_y);
                end
            end
            if (frame_done) nfd++;
            if (nfd > 0) tail++;
            @(posedge clk); #1;
        end
        checks++;
        if (nfd != 1) begin errors++; $display("FAIL rst_mid_frame_done got=%0d exp=1", nfd); end
    endtask

    task automatic test_back_to_back();
        int nfd = 0;
        for (int c = 0; c < 500 && nfd < 3; c++) begin
            lat[0] = $urandom_range(1, 4);
            lat[1] = $urandom_range(1, 4);
            drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), '0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, obs(), exp_vec);
            end
            if (frame_done) nfd++;
            @(posedge clk); #1;
        end
        checks++;
        if (nfd != 3) begin errors++; $display("FAIL back_to_back_frames got=%0d exp=3", nfd); end
    endtask

`ifdef PIXEL_SCHED_ABORT_EN
    task automatic test_abort();
        int mg = 0, nab = 0, nfd = 0;
        bit abdone = 0, restarted = 0, first = 1;
        lat[0] = 1; lat[1] = 6;
        for (int c = 0; c < 120 && nfd < 2; c++) begin
            bit ab, st;
            ab = (mg == 2) && !abdone;
            if (ab) abdone = 1;
            st = (c == 0) || (nfd == 1 && !restarted && m_phase == 0 && !m_fd);
            if (st && c != 0) restarted = 1;
            drive(st, 2'b11, '0, ab);
            if (|e_gnt) mg++;
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL abort cyc=%0d got=%b exp=%b", c, obs(), exp_vec);
            end
            if (restarted && |gnt && first) begin
                first = 0;
                checks++;
                if (gnt_x !== '0 || gnt_y !== '0) begin
                    errors++;
                    $display("FAIL abort_restart got=(%0d,%0d) exp=(0,0)", gnt_x, gnt_y);
                end
            end
            if (frame_done) nfd++;
            if (frame_done && aborted) nab++;
            @(posedge clk); #1;
        end
        checks++;
        if (nab != 1) begin errors++; $display("FAIL abort_pulse got=%0d exp=1", nab); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; req = '0; done_in = '0; ab_in = 1'b0;
        for (int i = 0; i < NR; i++) begin cnt[i] = 0; lat[i] = 1; end
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_alternate();
        test_single();
        test_spurious_done();
        test_drain();
        test_rst_mid();
        test_back_to_back();
`ifdef PIXEL_SCHED_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
